// File: rtl/jtag_pkg.sv
// Shared IEEE 1149.1 TAP definitions: state encodings and default IR length,
// reused by the TAP controller and the IR/DR blocks downstream of it.
package jtag_pkg;

   localparam int IR_LENGTH = 5;

   typedef enum logic [3:0] {
      TLR = 4'hF,
      RTI = 4'hC,
      SDS = 4'h7,
      CDR = 4'h6,
      SDR = 4'h2,
      E1D = 4'h1,
      PDR = 4'h3,
      E2D = 4'h0,
      UDR = 4'h5,
      SIS = 4'h4,
      CIR = 4'hE,
      SIR = 4'hA,
      E1I = 4'h9,
      PIR = 4'hB,
      E2I = 4'h8,
      UIR = 4'hD
   } tap_state_t;

endpackage

// File: rtl/jtag_tap_controller.sv
// 16-state TAP controller: TMS-steered FSM, Moore decode of the IR/DR strobes,
// TDO mux/enable and a saturating Run-Test/Idle cycle counter.
module jtag_tap_controller
   import jtag_pkg::*;
#(
   parameter int RTI_CNT_W = 16
) (
   input  logic                 TCK,
   input  logic                 RST,
   input  logic                 TMS,
   input  logic                 SO_IR_OUT,
   input  logic                 SO_DR_OUT,
   output logic [3:0]           TAP_STATE,
   output logic                 Reset_TAP,
   output logic                 Capture_IR,
   output logic                 Shift_IR,
   output logic                 Update_IR,
   output logic                 Capture_DR,
   output logic                 Shift_DR,
   output logic                 Update_DR,
   output logic                 Run_Idle,
   output logic                 TDO,
   output logic                 TDO_EN,
   output logic [RTI_CNT_W-1:0] RTI_COUNT
);

   tap_state_t             state;
   tap_state_t             state_nxt;
   logic [RTI_CNT_W-1:0]   rti_cnt;

   function automatic logic [RTI_CNT_W-1:0] sat_inc(input logic [RTI_CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   always_comb begin
      state_nxt = state;
      unique case (state)
         TLR: state_nxt = TMS ? TLR : RTI;
         RTI: state_nxt = TMS ? SDS : RTI;
         SDS: state_nxt = TMS ? SIS : CDR;
         CDR: state_nxt = TMS ? E1D : SDR;
         SDR: state_nxt = TMS ? E1D : SDR;
         E1D: state_nxt = TMS ? UDR : PDR;
         PDR: state_nxt = TMS ? E2D : PDR;
         E2D: state_nxt = TMS ? UDR : SDR;
         UDR: state_nxt = TMS ? SDS : RTI;
         SIS: state_nxt = TMS ? TLR : CIR;
         CIR: state_nxt = TMS ? E1I : SIR;
         SIR: state_nxt = TMS ? E1I : SIR;
         E1I: state_nxt = TMS ? UIR : PIR;
         PIR: state_nxt = TMS ? E2I : PIR;
         E2I: state_nxt = TMS ? UIR : SIR;
         UIR: state_nxt = TMS ? SDS : RTI;
         default: state_nxt = TLR;
      endcase
   end

   // Entering RTI from elsewhere leaves the count at zero; only edges spent in RTI count.
   always_ff @(posedge TCK) begin
      if (RST) begin
         state   <= TLR;
         rti_cnt <= '0;
      end else begin
         state <= state_nxt;
         if (state_nxt != RTI)
            rti_cnt <= '0;
         else if (state == RTI)
            rti_cnt <= sat_inc(rti_cnt);
      end
   end

   assign TAP_STATE  = state;
   assign Reset_TAP  = (state == TLR);
   assign Run_Idle   = (state == RTI);
   assign Capture_IR = (state == CIR);
   assign Shift_IR   = (state == SIR);
   assign Update_IR  = (state == UIR);
   assign Capture_DR = (state == CDR);
   assign Shift_DR   = (state == SDR);
   assign Update_DR  = (state == UDR);
   assign TDO_EN     = Shift_IR | Shift_DR;
   assign TDO        = Shift_IR ? SO_IR_OUT : (Shift_DR ? SO_DR_OUT : 1'b0);
   assign RTI_COUNT  = rti_cnt;

endmodule

// File: tb/tb_jtag_tap_controller.sv
// Directed bench for jtag_tap_controller with a small 5-bit IR hanging off the strobes.
module tb_jtag_tap_controller;

   localparam int RTI_CNT_W = 16;

   logic                 TCK = 1'b0;
   logic                 RST;
   logic                 TMS;
   logic                 SO_IR_OUT;
   logic                 SO_DR_OUT;
   logic [3:0]           TAP_STATE;
   logic                 Reset_TAP;
   logic                 Capture_IR, Shift_IR, Update_IR;
   logic                 Capture_DR, Shift_DR, Update_DR;
   logic                 Run_Idle;
   logic                 TDO, TDO_EN;
   logic [RTI_CNT_W-1:0] RTI_COUNT;

   int total = 0;
   int bad   = 0;

   jtag_tap_controller #(.RTI_CNT_W(RTI_CNT_W)) dut (
      .TCK(TCK), .RST(RST), .TMS(TMS),
      .SO_IR_OUT(SO_IR_OUT), .SO_DR_OUT(SO_DR_OUT),
      .TAP_STATE(TAP_STATE), .Reset_TAP(Reset_TAP),
      .Capture_IR(Capture_IR), .Shift_IR(Shift_IR), .Update_IR(Update_IR),
      .Capture_DR(Capture_DR), .Shift_DR(Shift_DR), .Update_DR(Update_DR),
      .Run_Idle(Run_Idle), .TDO(TDO), .TDO_EN(TDO_EN), .RTI_COUNT(RTI_COUNT)
   );

   always #5 TCK = ~TCK;

   // 5-bit IR: captures all-ones, shifts LSB out / TDI into MSB, updates on Update_IR.
   logic       tdi = 1'b0;
   logic [4:0] ir_sr = 5'b0;
   logic [4:0] ir_out = 5'b0;
   int         upd_ir_cnt = 0;
   int         upd_dr_cnt = 0;

   assign SO_IR_OUT = ir_sr[0];

   always @(posedge TCK) begin
      if (Capture_IR)
         ir_sr <= 5'b11111;
      else if (Shift_IR)
         ir_sr <= {tdi, ir_sr[4:1]};
      if (Update_IR) begin
         ir_out     <= ir_sr;
         upd_ir_cnt <= upd_ir_cnt + 1;
      end
      if (Update_DR)
         upd_dr_cnt <= upd_dr_cnt + 1;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic step(input logic t);
      TMS = t;
      @(posedge TCK);
      #1;
   endtask

   logic [3:0] ir_tms_v [12] = '{4'h0, 4'h1, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h1, 4'h0};
   logic [3:0] ir_exp   [12] = '{4'hC, 4'h7, 4'h4, 4'hE, 4'hA, 4'hA, 4'hA, 4'hA, 4'hA, 4'h9, 4'hD, 4'hC};
   logic [3:0] dr_tms_v [12] = '{4'h1, 4'h0, 4'h0, 4'h0, 4'h1, 4'h0, 4'h0, 4'h1, 4'h0, 4'h0, 4'h1, 4'h1};
   logic [3:0] dr_exp   [12] = '{4'h7, 4'h6, 4'h2, 4'h2, 4'h1, 4'h3, 4'h3, 4'h0, 4'h2, 4'h2, 4'h1, 4'h5};

   initial begin
      int         n_cap, n_sh, n_upd, k, upd0;
      logic [4:0] pat;
      logic [4:0] tdo_bits;
      logic [3:0] cur;
      logic [4:0] ir_snap;

      RST = 1'b1;
      TMS = 1'b1;
      SO_DR_OUT = 1'b0;

      // Reset state
      step(1'b1);
      RST = 1'b0;
      chk("rst_state", TAP_STATE, 4'hF);
      chk("rst_reset_tap", Reset_TAP, 1'b1);
      chk("rst_run_idle", Run_Idle, 1'b0);
      chk("rst_strobes", {Capture_IR, Shift_IR, Update_IR, Capture_DR, Shift_DR, Update_DR}, 6'b0);
      chk("rst_tdo", {TDO, TDO_EN}, 2'b00);
      chk("rst_rti_count", RTI_COUNT, 0);
      for (int i = 0; i < 3; i++) begin
         step(1'b1);
         chk("tlr_hold", {TAP_STATE, Reset_TAP}, {4'hF, 1'b1});
         chk("tlr_strobes", {Capture_IR, Shift_IR, Update_IR, Capture_DR, Shift_DR, Update_DR}, 6'b0);
      end

      // IR scan, 5 shifts of 10101
      pat = 5'b10101;
      n_cap = 0; n_sh = 0; n_upd = 0; k = 0;
      tdo_bits = 5'b0;
      cur = 4'hF;
      for (int i = 0; i < 12; i++) begin
         if (cur == 4'hA) begin
            tdi = pat[k];
            k++;
         end
         step(ir_tms_v[i][0]);
         cur = ir_exp[i];
         chk("ir_state", TAP_STATE, ir_exp[i]);
         if (Capture_IR) n_cap++;
         if (Shift_IR) begin
            tdo_bits = {TDO, tdo_bits[4:1]};
            n_sh++;
         end
         if (Update_IR) n_upd++;
         chk("ir_tdo_en", TDO_EN, (ir_exp[i] == 4'hA));
      end
      chk("ir_capture_cycles", n_cap, 1);
      chk("ir_shift_cycles", n_sh, 5);
      chk("ir_update_cycles", n_upd, 1);
      chk("ir_out", ir_out, 5'b10101);
      chk("ir_tdo_bits", tdo_bits, 5'b11111);
      chk("ir_run_idle", Run_Idle, 1'b1);

      // DR scan with pause
      SO_DR_OUT = 1'b1;
      upd0 = upd_dr_cnt;
      for (int i = 0; i < 12; i++) begin
         step(dr_tms_v[i][0]);
         chk("dr_state", TAP_STATE, dr_exp[i]);
         chk("dr_shift", Shift_DR, (dr_exp[i] == 4'h2));
         chk("dr_tdo_en", TDO_EN, (dr_exp[i] == 4'h2));
         chk("dr_tdo", TDO, (dr_exp[i] == 4'h2));
      end
      step(1'b0);
      chk("dr_end_rti", TAP_STATE, 4'hC);
      chk("dr_update_pulses", upd_dr_cnt - upd0, 1);
      SO_DR_OUT = 1'b0;

      // Five TMS=1 edges from Pause-IR
      step(1'b1); step(1'b1); step(1'b0); step(1'b0); step(1'b1); step(1'b0);
      chk("pir_reached", TAP_STATE, 4'hB);
      for (int i = 0; i < 4; i++) step(1'b1);
      chk("five_ones_4th", TAP_STATE, 4'h4);
      step(1'b1);
      chk("five_ones_5th", TAP_STATE, 4'hF);

      // Five TMS=1 edges from Pause-DR
      step(1'b0); step(1'b1); step(1'b0); step(1'b1); step(1'b0);
      chk("pdr_reached", TAP_STATE, 4'h3);
      for (int i = 0; i < 4; i++) step(1'b1);
      chk("five_ones_dr_4th", TAP_STATE, 4'h4);
      step(1'b1);
      chk("five_ones_dr_5th", TAP_STATE, 4'hF);

      // Reset aborts an IR scan
      step(1'b0); step(1'b1); step(1'b1); step(1'b0); step(1'b0);
      chk("abort_in_sir", TAP_STATE, 4'hA);
      ir_snap = ir_out;
      upd0 = upd_ir_cnt;
      tdi = 1'b0;
      step(1'b0);
      RST = 1'b1;
      step(1'b0);
      RST = 1'b0;
      chk("abort_state", TAP_STATE, 4'hF);
      chk("abort_shift_ir", Shift_IR, 1'b0);
      for (int i = 0; i < 4; i++) step(1'b1);
      chk("abort_no_update", upd_ir_cnt - upd0, 0);
      chk("abort_ir_out", ir_out, ir_snap);

      // RTI counter saturation
      step(1'b0);
      chk("rti_enter_count", RTI_COUNT, 0);
      step(1'b0);
      chk("rti_count_1", RTI_COUNT, 1);
      repeat (65533) step(1'b0);
      chk("rti_count_65534", RTI_COUNT, 65534);
      step(1'b0);
      chk("rti_count_max", RTI_COUNT, 65535);
      repeat (4000) step(1'b0);
      chk("rti_count_sat", RTI_COUNT, 65535);
      step(1'b1);
      chk("rti_leave_state", TAP_STATE, 4'h7);
      chk("rti_leave_count", RTI_COUNT, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/jtag_tap_controller.md
Name: jtag_tap_controller

Overview:
- IEEE 1149.1 16-state TAP controller FSM, clocked by TCK and steered by TMS.
- Sits directly upstream of the instruction register and the data registers.
- Produces the Capture/Shift/Update strobes for the IR and DR paths, the TAP reset indication and the TDO output mux/enable.
- Also provides a saturating Run-Test/Idle cycle counter for RUNBIST-style instructions.

Parameters:
- RTI_CNT_W, 16, width of the Run-Test/Idle cycle counter.

Ports:
- TCK  input  1  test clock; all state updates on its rising edge.
- RST  input  1  synchronous active-high reset, sampled on rising TCK.
- TMS  input  1  test mode select; drives FSM transitions.
- SO_IR_OUT  input  1  serial output of the instruction register.
- SO_DR_OUT  input  1  serial output of the currently selected data register.
- TAP_STATE  output  4  current state code.
- Reset_TAP  output  1  high while in Test-Logic-Reset.
- Capture_IR, Shift_IR, Update_IR  output  1 each  IR-path strobes.
- Capture_DR, Shift_DR, Update_DR  output  1 each  DR-path strobes.
- Run_Idle  output  1  high while in Run-Test/Idle.
- TDO  output  1  serial test data out.
- TDO_EN  output  1  TDO driver enable.
- RTI_COUNT  output  RTI_CNT_W  consecutive TCK cycles spent in Run-Test/Idle.

Behaviour:
State codes (hex), fixed by IEEE 1149.1:
- TLR=F, RTI=C, SDS=7, CDR=6, SDR=2, E1D=1, PDR=3, E2D=0, UDR=5
- SIS=4, CIR=E, SIR=A, E1I=9, PIR=B, E2I=8, UIR=D

Transitions on rising TCK, given as (TMS=0 / TMS=1):
- TLR: RTI / TLR
- RTI: RTI / SDS
- SDS: CDR / SIS
- CDR: SDR / E1D
- SDR: SDR / E1D
- E1D: PDR / UDR
- PDR: PDR / E2D
- E2D: SDR / UDR
- UDR: RTI / SDS
- SIS: CIR / TLR
- CIR: SIR / E1I
- SIR: SIR / E1I
- E1I: PIR / UIR
- PIR: PIR / E2I
- E2I: SIR / UIR
- UIR: RTI / SDS
- Five consecutive TMS=1 edges reach TLR from any state.

Reset:
- RST=1 at a rising edge forces state TLR and RTI_COUNT=0. RST has priority over TMS.
- Reset values of outputs: TAP_STATE=F, Reset_TAP=1, Run_Idle=0, all six strobes=0, TDO=0, TDO_EN=0, RTI_COUNT=0.
- RST asserted mid-shift aborts the scan: no Update strobe is issued.

Strobes (Moore, decoded combinationally from the state register; no extra latency):
- Capture_IR=(state==CIR), Shift_IR=(state==SIR), Update_IR=(state==UIR).
- DR strobes follow the same pattern on CDR/SDR/UDR.
- Exactly one strobe is high at a time; each strobe is high for exactly one TCK per visit, except Shift, which stays high while TMS=0.
- A downstream register acting on the rising edge while a strobe is high sees: capture on the CIR→SIR edge, one shift per edge in SIR, update on the UIR→next edge.

TDO path:
- TDO_EN=Shift_IR|Shift_DR.
- TDO=Shift_IR?SO_IR_OUT:(Shift_DR?SO_DR_OUT:0). Combinational; no added latency.

RTI counter:
- In RTI, RTI_COUNT increments on each rising edge and saturates at all-ones (no wrap).
- Cleared on any edge where the next state is not RTI.

Illegal or unreachable encodings: none are unused, since all 16 codes are defined.

Decomposition:
- Shared package jtag_pkg holds the 16 state localparams/typedef (4-bit, codes above) and the IR_LENGTH default (5). The IR and DR blocks reuse these.
- No sub-module needed; the FSM next-state, output decode and counter are flat in one module.

Test Plan:
- RST=1 for 1 edge, then TMS=1 for 3 edges → TAP_STATE=F, Reset_TAP=1, all strobes 0.
- From RTI, arbitrary state, TMS=1,1,1,1,1 → TAP_STATE=F after exactly the 5th edge.
- TLR, TMS=0,1,1,0,0,0,0,0,0,1,1,0 (IR scan, 5 shifts) → Capture_IR high 1 cycle, Shift_IR high 5 cycles, Update_IR high 1 cycle, ends in RTI; paired with a 5-bit IR, TDI=10101 loads IR_OUT=5'b10101 and TDO emits 11111.
- DR scan with pause: RTI, TMS=1,0,0,0,1,0,0,1,0,0,1,1 → Shift_DR deasserts through E1D/PDR/E2D, resumes in SDR, one Update_DR pulse; TDO_EN matches Shift_DR exactly.
- RST asserted while in SIR → next edge TAP_STATE=F, Update_IR never pulses, IR_OUT unchanged.
- Hold TMS=0 in RTI for 70000 edges with RTI_CNT_W=16 → RTI_COUNT saturates at 65535; one TMS=1 edge → 0.
